muldiv_seq: RTL and testbench

Iterative multiply/divide sequencer. It replaces the combinational Mul path with a multi-cycle unit that shares one adder/subtractor across iterations. It sits beside the ALU, takes the same operand-mux outputs, and returns a 32-bit result as resH/resL. It drives a stall line that gates the PC update while an operation is in flight.

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_dp.sv | 166 ++++++++++++++++
 rtl/muldiv_seq.sv | 102 ++++++++++
 tb/tb_muldiv_seq.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the iterative multiply/divide sequencer
//
// Purpose: state encoding, op field encodings and the default operand width
// shared by muldiv_seq and muldiv_dp.
// Ports: none (package).
// Optional feature macro: MULDIV_SIGNED_EN (consumed by muldiv_dp).

package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // op[0] selects the operation, op[OP_SIGNED] selects two's-complement mode
    localparam logic OP_MUL        = 1'b0;
    localparam logic OP_DIV        = 1'b1;
    localparam int   OP_SIGNED     = 1;

    localparam int   DEFAULT_WIDTH = 16;

endpackage

// File: rtl/muldiv_dp.sv
// rtl/muldiv_dp.sv - shift registers, shared adder/subtractor and sign fix-up for muldiv_seq
//
// Purpose: datapath of the iterative multiplier/divider. One (WIDTH+2)-bit
// adder is time-shared: it adds the multiplicand during MUL and
// trial-subtracts the divisor during DIV.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   load              capture op and operands (magnitudes in signed mode)
//   iterate           perform one shift-add / restoring-divide step
//   finish            final iteration: load fixed-up result into res_hi/res_lo
//   op                op[0] MUL/DIV, op[1] signed select (MULDIV_SIGNED_EN only)
//   operando1/2       multiplicand/dividend, multiplier/divisor
//   res_hi, res_lo    MUL: product high/low. DIV: remainder/quotient
// Optional feature macro: MULDIV_SIGNED_EN enables two's-complement operation.

module muldiv_dp
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             iterate,
    input  logic             finish,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operando1,
    input  logic [WIDTH-1:0] operando2,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int AW = WIDTH + 2;

    logic             op_div_r;
    logic [WIDTH-1:0] a_r;      // multiplicand (MUL) or divisor (DIV)
    logic [WIDTH-1:0] acc_r;    // product high half (MUL) or partial remainder (DIV)
    logic [WIDTH-1:0] q_r;      // multiplier shifting out (MUL) or quotient shifting in (DIV)

    logic             is_mul;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic [AW-1:0]    add_x;
    logic [AW-1:0]    add_y;
    logic [AW-1:0]    sum;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;

    assign is_mul = (op_div_r == OP_MUL);

`ifdef MULDIV_SIGNED_EN
    logic             neg1_r;   // operando1 was negative in signed mode
    logic             neg2_r;   // operando2 was negative in signed mode
    logic             zero2_r;  // divisor was zero: quotient stays all-ones
    logic             sgn;
    logic [2*WIDTH-1:0] prod;

    assign sgn  = op[OP_SIGNED];
    assign mag1 = (sgn && operando1[WIDTH-1]) ? -operando1 : operando1;
    assign mag2 = (sgn && operando2[WIDTH-1]) ? -operando2 : operando2;

    always_comb begin
        prod   = {acc_nxt, q_nxt};
        fix_hi = acc_nxt;
        fix_lo = q_nxt;
        if (is_mul) begin
            if (neg1_r ^ neg2_r) begin
                prod = -prod;
            end
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end else begin
            // remainder follows the dividend sign; quotient truncates toward zero
            if (neg1_r) begin
                fix_hi = -acc_nxt;
            end
            if ((neg1_r ^ neg2_r) && !zero2_r) begin
                fix_lo = -q_nxt;
            end
        end
    end
`else
    logic unused_sign_sel;

    assign unused_sign_sel = op[OP_SIGNED];
    assign mag1   = operando1;
    assign mag2   = operando2;
    assign fix_hi = acc_nxt;
    assign fix_lo = q_nxt;
`endif

    // Shared adder: MUL adds the multiplicand to the high half; DIV subtracts the
    // divisor from the remainder shifted left with the next dividend bit.
    always_comb begin
        if (is_mul) begin
            add_x = {2'b00, acc_r};
            add_y = {2'b00, a_r};
        end else begin
            add_x = {1'b0, acc_r, q_r[WIDTH-1]};
            add_y = ~{2'b00, a_r};
        end
        sum = add_x + add_y + {{(AW-1){1'b0}}, ~is_mul};
    end

    always_comb begin
        acc_nxt = acc_r;
        q_nxt   = q_r;
        if (is_mul) begin
            if (q_r[0]) begin
                {acc_nxt, q_nxt} = {sum[WIDTH:0], q_r[WIDTH-1:1]};
            end else begin
                {acc_nxt, q_nxt} = {1'b0, acc_r, q_r[WIDTH-1:1]};
            end
        end else if (!sum[AW-1]) begin
            // trial subtraction non-negative: keep it and set the quotient bit
            acc_nxt = sum[WIDTH-1:0];
            q_nxt   = {q_r[WIDTH-2:0], 1'b1};
        end else begin
            acc_nxt = {acc_r[WIDTH-2:0], q_r[WIDTH-1]};
            q_nxt   = {q_r[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_div_r <= 1'b0;
            a_r      <= '0;
            acc_r    <= '0;
            q_r      <= '0;
            res_hi   <= '0;
            res_lo   <= '0;
`ifdef MULDIV_SIGNED_EN
            neg1_r   <= 1'b0;
            neg2_r   <= 1'b0;
            zero2_r  <= 1'b0;
`endif
        end else begin
            if (load) begin
                op_div_r <= op[0];
                acc_r    <= '0;
                if (op[0] == OP_DIV) begin
                    a_r <= mag2;
                    q_r <= mag1;
                end else begin
                    a_r <= mag1;
                    q_r <= mag2;
                end
`ifdef MULDIV_SIGNED_EN
                neg1_r  <= sgn & operando1[WIDTH-1];
                neg2_r  <= sgn & operando2[WIDTH-1];
                zero2_r <= (operando2 == '0);
`endif
            end else if (iterate) begin
                acc_r <= acc_nxt;
                q_r   <= q_nxt;
            end
            if (finish) begin
                res_hi <= fix_hi;
                res_lo <= fix_lo;
            end
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative multiply/divide sequencer (FSM, counter, handshake)
//
// Purpose: accepts a MUL/DIV request, runs WIDTH iterations on muldiv_dp and
// pulses done with the result on resH/resL. stall holds the PC from the
// accepting cycle through the last RUN cycle.
// Ports:
//   CLOCK_50             system clock, rising edge
//   reset                asynchronous active-high reset
//   start                request pulse, accepted in IDLE or DONE
//   op                   op[0] 0=MUL 1=DIV, op[1] signed select
//   operando1/operando2  operands, sampled on the accepting edge
//   busy                 high while in RUN
//   done                 one-cycle pulse, results valid
//   stall                combinational (start & accept) | busy
//   resH/resL            MUL: product high/low. DIV: remainder/quotient
// Optional feature macro: MULDIV_SIGNED_EN (signed operation, in muldiv_dp).

module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operando1,
    input  logic [WIDTH-1:0] operando2,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] resH,
    output logic [WIDTH-1:0] resL
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             load;
    logic             iterate;
    logic             finish;

    assign accept  = (state == IDLE) || (state == DONE);
    assign load    = start & accept;
    assign iterate = (state == RUN);
    assign finish  = iterate && (cnt == CNT_W'(1));
    // combinational so the PC is already held on the accepting edge
    assign stall   = load | busy;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        cnt   <= CNT_W'(WIDTH);
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    muldiv_dp #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk      (CLOCK_50),
        .rst      (reset),
        .load     (load),
        .iterate  (iterate),
        .finish   (finish),
        .op       (op),
        .operando1(operando1),
        .operando2(operando2),
        .res_hi   (resH),
        .res_lo   (resL)
    );

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - self-checking bench for muldiv_seq against a behavioural model

module tb_muldiv_seq;

    localparam int W = 16;

    logic         clk   = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op    = 2'b00;
    logic [W-1:0] opa   = '0;
    logic [W-1:0] opb   = '0;
    logic         busy;
    logic         done;
    logic         stall;
    logic [W-1:0] res_h;
    logic [W-1:0] res_l;

    int checks   = 0;
    int failures = 0;

    muldiv_seq #(.WIDTH(W)) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .operando1(opa),
        .operando2(opb),
        .busy     (busy),
        .done     (done),
        .stall    (stall),
        .resH     (res_h),
        .resL     (res_l)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic result {hi, lo} straight from the operation definitions.
    function automatic logic [31:0] model_result(input logic [1:0] o, input logic [W-1:0] a,
                                                 input logic [W-1:0] b);
        logic [31:0] r;
        int sa;
        int sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (o[0] == 1'b0)  r = {16'h0000, a} * {16'h0000, b};
        else if (b == '0)  r = {a, 16'hFFFF};
        else               r = {a % b, a / b};
`ifdef MULDIV_SIGNED_EN
        if (o[1]) begin
            if (o[0] == 1'b0)  r = 32'(sa * sb);
            else if (sb == 0)  r = {a, 16'hFFFF};
            else               r = {16'(sa % sb), 16'(sa / sb)};
        end
`endif
        return r;
    endfunction

    // Cycle-level model: an accepted request completes WIDTH+1 cycles later.
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    int          m_left = 0;
    logic [W-1:0] m_h = '0;
    logic [W-1:0] m_l = '0;
    logic [31:0] m_pend = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_left = 0;
            m_h    = '0;
            m_l    = '0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                {m_h, m_l} = m_pend;
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_pend = model_result(op, opa, opb);
                m_busy = 1'b1;
                m_left = W;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy",  32'(busy),  32'(m_busy));
        chk("done",  32'(done),  32'(m_done));
        chk("stall", 32'(stall), 32'((start && !m_busy) || m_busy));
        chk("resH",  32'(res_h), 32'(m_h));
        chk("resL",  32'(res_l), 32'(m_l));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        op    = o;
        opa   = a;
        opb   = b;
        start = 1'b1;
    endtask

    // Count cycles after the start edge until done; first = cycle number of the next negedge.
    task automatic wait_done(input string name, input int first);
        int n;
        bit seen;
        n    = first;
        seen = 1'b0;
        for (int i = first; i <= 40; i++) begin
            @(negedge clk);
            n = i;
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!seen) n = -1;
        chk({name, " latency"}, 32'(n), 32'd17);
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
        tick();
        issue(o, a, b);
        @(negedge clk);
        #1;
        chk({name, " stall@accept"}, 32'(stall), 32'd1);
        tick();
        start = 1'b0;
        wait_done(name, 1);
        chk({name, " resH"}, 32'(res_h), 32'(eh));
        chk({name, " resL"}, 32'(res_l), 32'(el));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen_done;
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy",  32'(busy),  32'd0);
        chk("reset done",  32'(done),  32'd0);
        chk("reset stall", 32'(stall), 32'd0);
        chk("reset resH",  32'(res_h), 32'd0);
        chk("reset resL",  32'(res_l), 32'd0);
        reset = 1'b0;

        chk("model mul300", model_result(2'b00, 16'h012C, 16'h012C), 32'h0001_5F90);
        chk("model div0",   model_result(2'b01, 16'h1234, 16'h0000), 32'h1234_FFFF);

        run_op("mul300",   2'b00, 16'h012C, 16'h012C, 16'h0001, 16'h5F90);
        run_op("mulmax",   2'b00, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001);
        run_op("div1000",  2'b01, 16'd1000, 16'd7,    16'h0006, 16'h008E);
        run_op("divzero",  2'b01, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF);
        run_op("div8000",  2'b01, 16'h8000, 16'h0003, 16'h0002, 16'h2AAA);

        // start during RUN is ignored, then back-to-back start in DONE
        tick();
        issue(2'b00, 16'd5, 16'd6);
        tick();
        start = 1'b0;
        repeat (4) tick();
        issue(2'b00, 16'd7, 16'd8);
        tick();
        start = 1'b0;
        wait_done("ignored", 6);
        chk("ignored resL", 32'(res_l), 32'h001E);
        chk("ignored resH", 32'(res_h), 32'h0000);
        #1;
        issue(2'b00, 16'd7, 16'd8);
        #1;
        chk("b2b stall@done", 32'(stall), 32'd1);
        chk("b2b busy@done",  32'(busy),  32'd0);
        tick();
        start = 1'b0;
        wait_done("b2b", 1);
        chk("b2b resL", 32'(res_l), 32'h0038);

        // reset in the middle of RUN
        tick();
        issue(2'b00, 16'd9, 16'd9);
        tick();
        start = 1'b0;
        repeat (7) tick();
        reset = 1'b1;
        #1;
        chk("midreset busy", 32'(busy),  32'd0);
        chk("midreset done", 32'(done),  32'd0);
        chk("midreset resH", 32'(res_h), 32'd0);
        chk("midreset resL", 32'(res_l), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        chk("midreset no done", 32'(seen_done), 32'd0);
        run_op("mul2x3", 2'b00, 16'd2, 16'd3, 16'h0000, 16'h0006);

`ifdef MULDIV_SIGNED_EN
        run_op("smul",  2'b10, 16'hFFFD, 16'h0005, 16'hFFFF, 16'hFFF1);
        run_op("sdiv",  2'b11, 16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD);
        run_op("sdiv0", 2'b11, 16'hFFF9, 16'h0000, 16'hFFF9, 16'hFFFF);
`else
        run_op("smul",  2'b10, 16'hFFFD, 16'h0005, 16'h0004, 16'hFFF1);
        run_op("sdiv",  2'b11, 16'hFFF9, 16'h0002, 16'h0001, 16'h7FFC);
`endif

        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
